// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed common-cathode 7-segment display. Each digit is
// decoded once its strobe/segment pair has been stable long enough.
// Completed frames are handed out on a valid/ready output.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [6:0]              i_segment,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic [NUM_DIGITS-1:0]   o_err,
    output logic                    o_overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);

    // Returns {error, nibble}; unknown patterns give nibble 0 with error set.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F: r = 5'h00;  7'h06: r = 5'h01;
            7'h5B: r = 5'h02;  7'h4F: r = 5'h03;
            7'h66: r = 5'h04;  7'h6D: r = 5'h05;
            7'h7D: r = 5'h06;  7'h07: r = 5'h07;
            7'h7F: r = 5'h08;  7'h67: r = 5'h09;
            7'h77: r = 5'h0A;  7'h7C: r = 5'h0B;
            7'h39: r = 5'h0C;  7'h5E: r = 5'h0D;
            7'h79: r = 5'h0E;  7'h71: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [6:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   en_s1_q, en_s2_q;
    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [6:0]              ref_seg_q, ref_seg_d;
    logic [NUM_DIGITS-1:0]   ref_en_q, ref_en_d;
    logic [4*NUM_DIGITS-1:0] dig_val_q, dig_val_d;
    logic [NUM_DIGITS-1:0]   dig_err_q, dig_err_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    overrun_q, overrun_d;

    logic       frame_done;
    logic       same;
    logic       onehot;
    logic [4:0] dec;

    assign frame_done = &mask_q;
    assign same       = (seg_s2_q == ref_seg_q) && (en_s2_q == ref_en_q);
    assign onehot     = $onehot(en_s2_q);
    assign dec        = decode_seg(ref_seg_q);

    // Two-flop synchronizers for the asynchronous display pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            en_s1_q  <= '0;
            en_s2_q  <= '0;
        end else begin
            seg_s1_q <= i_segment;
            seg_s2_q <= seg_s1_q;
            en_s1_q  <= i_digit_en;
            en_s2_q  <= en_s1_q;
        end
    end

    // Capture FSM: stability tracking, digit write and mask update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_seg_d = ref_seg_q;
        ref_en_d  = ref_en_q;
        dig_val_d = dig_val_q;
        dig_err_d = dig_err_q;
        // A completing frame clears the mask; a capture on the same edge
        // still lands in the fresh mask below.
        mask_d    = frame_done ? '0 : mask_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (onehot) begin
                    state_d   = SETTLE;
                    cnt_d     = 8'd1;
                    ref_seg_d = seg_s2_q;
                    ref_en_d  = en_s2_q;
                end
            end
            SETTLE, HELD: begin
                if (!same) begin
                    if (onehot) begin
                        state_d   = SETTLE;
                        cnt_d     = 8'd1;
                        ref_seg_d = seg_s2_q;
                        ref_en_d  = en_s2_q;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (state_q == SETTLE) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == STABLE_LAST) begin
                        state_d = HELD;
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            if (ref_en_q[k]) begin
                                dig_val_d[4*k +: 4] = dec[3:0];
                                dig_err_d[k]        = dec[4];
                                mask_d[k]           = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output handshake: load, hold, drop-with-overrun and accept.
    always_comb begin
        valid_d   = valid_q;
        value_d   = value_q;
        err_d     = err_q;
        overrun_d = 1'b0;
        if (frame_done) begin
            if (valid_q && !i_ready) begin
                overrun_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                value_d = dig_val_q;
                err_d   = dig_err_q;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers for the capture FSM and the output frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ref_seg_q <= '0;
            ref_en_q  <= '0;
            dig_val_q <= '0;
            dig_err_q <= '0;
            mask_q    <= '0;
            valid_q   <= 1'b0;
            value_q   <= '0;
            err_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_seg_q <= ref_seg_d;
            ref_en_q  <= ref_en_d;
            dig_val_q <= dig_val_d;
            dig_err_q <= dig_err_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            value_q   <= value_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_value   = value_q;
    assign o_err     = err_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a frame scoreboard.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  en;
    logic        ready;
    logic        o_valid;
    logic [15:0] o_value;
    logic [3:0]  o_err;
    logic        o_overrun;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int ovr_cnt = 0;
    logic [15:0] exp_val_q[$];
    logic [3:0]  exp_err_q[$];

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_segment  (seg),
        .i_digit_en (en),
        .i_ready    (ready),
        .o_valid    (o_valid),
        .o_value    (o_value),
        .o_err      (o_err),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        logic [6:0] pats [4];
        pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
        for (int k = 0; k < 4; k++) begin
            en  = 4'(1 << k);
            seg = pats[k];
            step(20);
        end
        en  = '0;
        seg = '0;
        step(4);
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e);
        exp_val_q.push_back(v);
        exp_err_q.push_back(e);
    endtask

    // Scoreboard: every accepted frame is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_overrun) ovr_cnt++;
            if (o_valid && ready) begin
                acc_cnt++;
                if (exp_val_q.size() == 0) begin
                    check("unexpected_frame", {16'h0, o_value}, 32'hFFFF_FFFF);
                end else begin
                    check("frame_value", {16'h0, o_value}, {16'h0, exp_val_q.pop_front()});
                    check("frame_err", {28'h0, o_err}, {28'h0, exp_err_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        seg   = '0;
        en    = '0;
        ready = 1'b1;
        step(3);
        check("rst_valid", {31'h0, o_valid}, 0);
        check("rst_value", {16'h0, o_value}, 0);
        check("rst_err", {28'h0, o_err}, 0);
        check("rst_overrun", {31'h0, o_overrun}, 0);
        rst_n = 1'b1;
        step(3);

        // Latency: steady pin change to digit register update
        en  = 4'b0001;
        seg = 7'h06;
        step(9);
        check("lat_before", {31'h0, dut.mask_q[0]}, 0);
        step(1);
        check("lat_at", {31'h0, dut.mask_q[0]}, 1);
        check("lat_nibble", {28'h0, dut.dig_val_q[3:0]}, 1);
        en  = '0;
        seg = '0;
        step(4);

        // Basic frame, digit 0 recaptured over the earlier value
        push(16'h0743, 4'b0000);
        scan(7'h4F, 7'h66, 7'h07, 7'h3F);
        check("s1_accepts", acc_cnt, 1);
        check("s1_queue", exp_val_q.size(), 0);
        check("s1_valid_low", {31'h0, o_valid}, 0);

        // Undecodable pattern on digit 1
        push(16'h3201, 4'b0010);
        scan(7'h06, 7'h2A, 7'h5B, 7'h4F);
        check("s2_accepts", acc_cnt, 2);

        // Segment toggling faster than the stability window
        en = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            seg = (i % 2 == 1) ? 7'h06 : 7'h3F;
            step(5);
        end
        check("s3_mask", {28'h0, dut.mask_q}, 0);
        check("s3_valid", {31'h0, o_valid}, 0);
        en  = '0;
        seg = '0;
        step(4);

        // Non-one-hot strobe
        en  = 4'b0011;
        seg = 7'h3F;
        step(50);
        check("s4_state", 32'(dut.state_q), 0);
        check("s4_cnt", {24'h0, dut.cnt_q}, 0);
        check("s4_mask", {28'h0, dut.mask_q}, 0);
        check("s4_accepts", acc_cnt, 2);
        en  = '0;
        seg = '0;
        step(4);

        // Back-pressure: second frame dropped with one overrun pulse
        ready = 1'b0;
        scan(7'h4F, 7'h66, 7'h07, 7'h3F);
        check("s5_valid_a", {31'h0, o_valid}, 1);
        check("s5_value_a", {16'h0, o_value}, 32'h0743);
        check("s5_ovr_a", ovr_cnt, 0);
        scan(7'h7F, 7'h67, 7'h06, 7'h5B);
        check("s5_ovr_b", ovr_cnt, 1);
        check("s5_valid_b", {31'h0, o_valid}, 1);
        check("s5_value_b", {16'h0, o_value}, 32'h0743);
        check("s5_mask", {28'h0, dut.mask_q}, 0);
        push(16'h0743, 4'b0000);
        ready = 1'b1;
        step(3);
        check("s5_accepts", acc_cnt, 3);
        check("s5_valid_low", {31'h0, o_valid}, 0);

        // Reset with a held frame and digit 2 mid-settle
        ready = 1'b0;
        scan(7'h77, 7'h7C, 7'h79, 7'h71);
        check("s6_held", {16'h0, o_value}, 32'hFEBA);
        en = 4'b0001; seg = 7'h6D; step(20);
        en = 4'b0010; seg = 7'h7D; step(20);
        en = 4'b0100; seg = 7'h39; step(5);
        check("s6_settle", 32'(dut.state_q), 1);
        rst_n = 1'b0;
        #2;
        check("s6_rst_valid", {31'h0, o_valid}, 0);
        check("s6_rst_value", {16'h0, o_value}, 0);
        check("s6_rst_err", {28'h0, o_err}, 0);
        check("s6_rst_ovr", {31'h0, o_overrun}, 0);
        check("s6_rst_mask", {28'h0, dut.mask_q}, 0);
        check("s6_rst_cnt", {24'h0, dut.cnt_q}, 0);
        step(3);
        en    = '0;
        seg   = '0;
        ready = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(2);
        check("s6_no_ovr", ovr_cnt, 1);
        push(16'hDC65, 4'b0000);
        scan(7'h6D, 7'h7D, 7'h39, 7'h5E);
        check("s6_accepts", acc_cnt, 4);
        check("s6_queue", exp_val_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
